barcode_rcv: RTL and testbench

BARCODE_RCV -- requirements
Module: barcode_rcv

---
 rtl/barcode_rcv.sv | 118 +++++++++++
 tb/tb_barcode_rcv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/barcode_rcv.sv
// ============================================================================
// Module  : barcode_rcv
// Brief   : Serial barcode station-ID receiver (start bit sets sample point T).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module barcode_rcv #(
  parameter int TIMER_W = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       BC,
  input  logic       clr_ID_vld,
  output logic [7:0] ID,
  output logic       ID_vld
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_FALL = 2'd2,
    SAMPLE    = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] c_TIMER_MAX = '1;

  state_t               state_q;
  logic                 bc_s1_q, bc_s2_q, bc_s3_q;
  logic [TIMER_W-1:0]   timer_q, period_q;
  logic [3:0]           cnt_q;
  logic [7:0]           shift_q;

  logic                 fall, rise;
  logic [TIMER_W-1:0]   timer_d;
  logic [3:0]           cnt_d;
  logic [7:0]           shift_d;

  assign fall    = bc_s3_q & ~bc_s2_q;
  assign rise    = ~bc_s3_q & bc_s2_q;
  // Saturating timer: a stuck line must time out, never wrap into a false match.
  assign timer_d = (timer_q == c_TIMER_MAX) ? timer_q : timer_q + 1'b1;
  assign cnt_d   = cnt_q + 4'd1;
  assign shift_d = {shift_q[6:0], bc_s2_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_s1_q  <= 1'b1;
      bc_s2_q  <= 1'b1;
      bc_s3_q  <= 1'b1;
      state_q  <= IDLE;
      timer_q  <= '0;
      period_q <= '0;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      ID       <= 8'h00;
      ID_vld   <= 1'b0;
    end else begin
      bc_s1_q <= BC;
      bc_s2_q <= bc_s1_q;
      bc_s3_q <= bc_s2_q;

      // A coinciding frame completion below overrides this clear.
      if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (fall) begin
            timer_q <= '0;
            cnt_q   <= 4'd0;
            state_q <= START;
          end
        end
        START: begin
          timer_q <= timer_d;
          if (rise) begin
            period_q <= timer_q;
            state_q  <= WAIT_FALL;
          end else if (timer_q == c_TIMER_MAX) begin
            state_q <= IDLE;
          end
        end
        WAIT_FALL: begin
          if (fall) begin
            timer_q <= '0;
            state_q <= SAMPLE;
          end else if (timer_q == c_TIMER_MAX) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        SAMPLE: begin
          timer_q <= timer_d;
          if (timer_q == period_q) begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            if (cnt_d < 4'd8) begin
              state_q <= WAIT_FALL;
            end else begin
              state_q <= IDLE;
              if (shift_d[7:6] == 2'b00) begin
                ID     <= shift_d;
                ID_vld <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_barcode_rcv.sv
// ============================================================================
// Module  : tb_barcode_rcv
// Brief   : Scoreboard bench for barcode_rcv with directed and random frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barcode_rcv;

  localparam int TW = 12;  // shortened timer so timeouts fit the cycle budget

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       BC = 1'b1;
  logic       clr = 1'b0;
  logic [7:0] ID;
  logic       ID_vld;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] id;
    int         deadline;
  } exp_t;
  exp_t q[$];

  logic [7:0] m_id  = 8'h00;
  logic       m_vld = 1'b0;

  barcode_rcv #(.TIMER_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .BC        (BC),
    .clr_ID_vld(clr),
    .ID        (ID),
    .ID_vld    (ID_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      BC  = 1'b1;
      clr = 1'b0;
    end
  endtask

  // One bit cell: low for 'low' clocks then high; clr pulsed on cycle clr_at.
  task automatic send_bit(input int low, input int per, input int clr_at);
    for (int i = 0; i < per; i++) begin
      tick();
      BC  = (i < low) ? 1'b0 : 1'b1;
      clr = (i == clr_at) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic send_partial(input logic [7:0] d, input int t, input int per, input int nbits);
    send_bit(t, per, -1);
    for (int b = 7; b > 7 - nbits; b--) send_bit(d[b] ? t / 2 : t + t / 2, per, -1);
  endtask

  task automatic send_frame(input logic [7:0] d, input int t, input int per, input bit coincide);
    bit   valid;
    exp_t e;
    valid = (d[7:6] == 2'b00);
    send_partial(d, t, per, 7);
    if (valid) begin
      e.id       = d;
      e.deadline = cyc + 1 + t + 5;
      q.push_back(e);
    end
    send_bit(d[0] ? t / 2 : t + t / 2, per, coincide ? t + 2 : -1);
    if (coincide) m_vld = 1'b0;
    if (valid) begin
      m_id  = d;
      m_vld = 1'b1;
    end
  endtask

  task automatic post_check(input string tag);
    idle(4);
    check({tag, "_pending"}, q.size(), 0);
    if (q.size() != 0) q.delete();
    check({tag, "_ID"}, ID, m_id);
    check({tag, "_ID_vld"}, ID_vld, m_vld);
  endtask

  task automatic pulse_clr(input string tag);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_vld = 1'b0;
    check({tag, "_ID_vld"}, ID_vld, 1'b0);
    check({tag, "_ID"}, ID, m_id);
  endtask

  // Monitor: every new load (ID_vld rising or ID changing while valid) pops one entry.
  initial begin
    logic [7:0] p_id;
    logic       p_vld;
    exp_t       e;
    p_id  = 8'h00;
    p_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ID_vld && (!p_vld || ID != p_id)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: actual ID=%0h, no load expected", ID);
        end else begin
          e = q.pop_front();
          check("load_ID", ID, e.id);
          check("load_latency_ok", cyc <= e.deadline, 1'b1);
        end
      end
      p_id  = ID;
      p_vld = ID_vld;
    end
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         t;
    bit         co;

    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      BC = 1'($urandom_range(0, 1));
    end
    check("reset_ID", ID, 8'h00);
    check("reset_ID_vld", ID_vld, 1'b0);
    BC = 1'b1;
    tick();
    rst_n = 1'b1;
    idle(20);
    check("post_reset_ID", ID, 8'h00);
    check("post_reset_ID_vld", ID_vld, 1'b0);

    send_frame(8'h13, 100, 400, 1'b0);
    post_check("frame13");
    pulse_clr("clr13");
    send_frame(8'h2A, 100, 400, 1'b1);
    post_check("frame2A_coincident_clr");
    pulse_clr("clr2A");
    send_frame(8'hC5, 100, 400, 1'b0);
    post_check("invalidC5");

    tick();
    BC = 1'b0;
    idle(0);
    for (int i = 0; i < 5000; i++) tick();
    idle(50);
    post_check("timeout_start");
    send_partial(8'h5A, 100, 400, 3);
    idle(5000);
    post_check("timeout_wait_fall");
    send_frame(8'h2E, 100, 400, 1'b0);
    post_check("frame2E");

    send_partial(8'h35, 100, 400, 4);
    tick();
    rst_n = 1'b0;
    idle(3);
    m_id  = 8'h00;
    m_vld = 1'b0;
    check("midframe_reset_ID", ID, 8'h00);
    check("midframe_reset_ID_vld", ID_vld, 1'b0);
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h1A, 100, 400, 1'b0);
    post_check("frame1A");

    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[7:6] = 2'b00;
      if (d[7:6] == 2'b00 && m_vld && d == m_id) d = d ^ 8'h01;
      t  = $urandom_range(8, 60);
      co = ($urandom_range(0, 3) == 0);
      send_frame(d, t, 3 * t + 8, co);
      post_check("random_frame");
      if ($urandom_range(0, 2) == 0) pulse_clr("random_clr");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
